// File: rtl/bcd_pkg.sv
// Shared constants, FSM encoding and digit-count helper for the binary-to-BCD converter.
package bcd_pkg;

  localparam int unsigned BIN_W_DEF      = 24;
  localparam int unsigned OUT_DIGITS_DEF = 6;

  localparam logic [3:0] ADD3 = 4'd3;
  localparam logic [3:0] NINE = 4'd9;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StShift = 2'd1,
    StDone  = 2'd2
  } state_e;

  // Decimal digits needed to hold 2^bin_w - 1 (1233/4096 ~ log10(2)).
  function automatic int unsigned full_digits(input int unsigned bin_w);
    return ((bin_w * 1233) >> 12) + 1;
  endfunction

endpackage

// File: rtl/bcd_add3_col.sv
// One double-dabble correction column: adds 3 to a BCD nibble that is 5 or more.
module bcd_add3_col
  import bcd_pkg::*;
(
  input  logic [3:0] nib_i,
  output logic [3:0] nib_o
);

  always_comb begin
    nib_o = (nib_i >= 4'd5) ? nib_i + ADD3 : nib_i;
  end

endmodule

// File: rtl/bin_to_bcd_seq.sv
// Sequential shift-and-add-3 binary-to-BCD converter feeding the six-digit 7-seg display path.
module bin_to_bcd_seq
  import bcd_pkg::*;
#(
  parameter int unsigned BIN_W      = BIN_W_DEF,
  parameter int unsigned OUT_DIGITS = OUT_DIGITS_DEF,
  parameter bit          SATURATE   = 1'b0
) (
  input  logic                    clk_clk,
  input  logic                    reset_reset,
  input  logic [BIN_W-1:0]        in_data,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [4*OUT_DIGITS-1:0] digits_out,
  output logic                    overflow,
  output logic                    out_valid,
  output logic                    busy
);

  localparam int unsigned FULL_DIGITS = full_digits(BIN_W);
  localparam int unsigned BCD_W       = 4 * FULL_DIGITS;
  localparam int unsigned SR_W        = BCD_W + BIN_W;
  localparam int unsigned CNT_W       = $clog2(BIN_W + 1);

  state_e                  state_q, state_d;
  logic [SR_W-1:0]         sr_q, sr_d, sr_corr;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [4*OUT_DIGITS-1:0] digits_q, digits_d;
  logic                    ovf_q, ovf_d;
  logic                    out_valid_q, out_valid_d;
  logic [BCD_W-1:0]        bcd_corr;
  logic [BCD_W-1:0]        bcd_fin;
  logic                    ovf_raw;

  // All BCD columns are corrected in parallel before each shift.
  for (genvar g = 0; g < FULL_DIGITS; g++) begin : g_col
    bcd_add3_col u_col (
      .nib_i(sr_q[BIN_W + 4*g +: 4]),
      .nib_o(bcd_corr[4*g +: 4])
    );
  end

  assign sr_corr = {bcd_corr, sr_q[BIN_W-1:0]};
  assign bcd_fin = sr_q[SR_W-1 -: BCD_W];

  // Any nonzero digit above the displayed ones means the value does not fit.
  always_comb begin
    ovf_raw = 1'b0;
    for (int unsigned i = OUT_DIGITS; i < FULL_DIGITS; i++) begin
      ovf_raw = ovf_raw | (|bcd_fin[4*i +: 4]);
    end
  end

  always_comb begin
    state_d     = state_q;
    sr_d        = sr_q;
    cnt_d       = cnt_q;
    digits_d    = digits_q;
    ovf_d       = ovf_q;
    out_valid_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          sr_d    = {{BCD_W{1'b0}}, in_data};
          cnt_d   = CNT_W'(BIN_W);
          state_d = StShift;
        end
      end
      StShift: begin
        sr_d  = {sr_corr[SR_W-2:0], 1'b0};
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) state_d = StDone;
      end
      StDone: begin
        if (SATURATE && ovf_raw) digits_d = {OUT_DIGITS{NINE}};
        else                     digits_d = bcd_fin[4*OUT_DIGITS-1:0];
        ovf_d       = ovf_raw;
        out_valid_d = 1'b1;
        state_d     = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      state_q     <= StIdle;
      sr_q        <= '0;
      cnt_q       <= '0;
      digits_q    <= '0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      sr_q        <= sr_d;
      cnt_q       <= cnt_d;
      digits_q    <= digits_d;
      ovf_q       <= ovf_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready   = (state_q == StIdle);
  assign busy       = ~in_ready;
  assign digits_out = digits_q;
  assign overflow   = ovf_q;
  assign out_valid  = out_valid_q;

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Randomised self-checking bench for bin_to_bcd_seq (wrap-around and saturating instances).
module tb_bin_to_bcd_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic [23:0] in_data;
  logic        in_valid;

  logic        rdy, busy, ovf, ovld;
  logic [23:0] dig;
  logic        rdy_s, busy_s, ovf_s, ovld_s;
  logic [23:0] dig_s;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  bin_to_bcd_seq #(.BIN_W(24), .OUT_DIGITS(6), .SATURATE(1'b0)) dut (
    .clk_clk    (clk),
    .reset_reset(rst),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (rdy),
    .digits_out (dig),
    .overflow   (ovf),
    .out_valid  (ovld),
    .busy       (busy)
  );

  bin_to_bcd_seq #(.BIN_W(24), .OUT_DIGITS(6), .SATURATE(1'b1)) dut_sat (
    .clk_clk    (clk),
    .reset_reset(rst),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (rdy_s),
    .digits_out (dig_s),
    .overflow   (ovf_s),
    .out_valid  (ovld_s),
    .busy       (busy_s)
  );

  // Reference: decimal digits by plain division.
  function automatic logic [23:0] model_digits(input int unsigned v, input bit sat);
    logic [23:0] r;
    int unsigned x;
    if (sat && v > 999999) return 24'h999999;
    x = v % 1000000;
    for (int i = 0; i < 6; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic convert(input logic [23:0] v, input string name);
    int          lat;
    bit          busy_ok, hold_ok;
    logic [23:0] prev;
    logic        exp_ovf;
    exp_ovf  = (int'(v) > 999999);
    prev     = dig;
    busy_ok  = 1'b1;
    hold_ok  = 1'b1;
    in_data  = v;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    lat      = 0;
    while (!ovld && lat < 40) begin
      if (busy !== 1'b1 || rdy !== 1'b0) busy_ok = 1'b0;
      if (dig !== prev) hold_ok = 1'b0;
      tick();
      lat++;
    end
    checks++;
    if (lat != 25) begin
      errors++;
      $display("FAIL %s latency: got %0d edges, want 25", name, lat);
    end
    checks++;
    if (!busy_ok) begin
      errors++;
      $display("FAIL %s busy_window: busy/in_ready wrong during conversion, want busy=1 ready=0", name);
    end
    checks++;
    if (!hold_ok) begin
      errors++;
      $display("FAIL %s hold: digits_out changed during conversion, want %h held", name, prev);
    end
    checks++;
    if (dig !== model_digits(v, 1'b0) || ovf !== exp_ovf) begin
      errors++;
      $display("FAIL %s wrap: got digits=%h ovf=%b, want digits=%h ovf=%b",
               name, dig, ovf, model_digits(v, 1'b0), exp_ovf);
    end
    checks++;
    if (dig_s !== model_digits(v, 1'b1) || ovf_s !== exp_ovf || ovld_s !== 1'b1) begin
      errors++;
      $display("FAIL %s sat: got digits=%h ovf=%b vld=%b, want digits=%h ovf=%b vld=1",
               name, dig_s, ovf_s, ovld_s, model_digits(v, 1'b1), exp_ovf);
    end
    checks++;
    if (rdy !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL %s ready_after: got ready=%b busy=%b, want 1/0", name, rdy, busy);
    end
    tick();
    checks++;
    if (ovld !== 1'b0) begin
      errors++;
      $display("FAIL %s pulse_width: out_valid=%b on second cycle, want 0", name, ovld);
    end
  endtask

  task automatic test_reset();
    rst      = 1'b1;
    in_valid = 1'b0;
    in_data  = '0;
    tick();
    tick();
    rst = 1'b0;
    checks++;
    if (rdy !== 1'b1 || busy !== 1'b0 || dig !== 24'h0 || ovf !== 1'b0 || ovld !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: got rdy=%b busy=%b dig=%h ovf=%b vld=%b, want 1 0 000000 0 0",
               rdy, busy, dig, ovf, ovld);
    end
    convert(24'd0, "zero");
  endtask

  task automatic test_directed();
    convert(24'd123456, "d123456");
    convert(24'd999999, "d999999");
    convert(24'd1000000, "d1000000");
    convert(24'd16777215, "dmax");
  endtask

  task automatic test_random();
    logic [23:0] v;
    for (int i = 0; i < 16; i++) begin
      if (i % 2 == 0) v = 24'($urandom_range(0, 999999));
      else            v = 24'($urandom_range(0, 24'hFFFFFF));
      convert(v, $sformatf("rand%0d", i));
    end
  endtask

  task automatic test_back_to_back();
    logic [23:0] exp_q[$];
    int          acc_q[$];
    int          n_out;
    bit          pair_ok;
    logic [23:0] e;
    n_out    = 0;
    pair_ok  = 1'b1;
    in_valid = 1'b1;
    in_data  = 24'($urandom_range(0, 24'hFFFFFF));
    for (int cyc = 0; cyc < 130; cyc++) begin
      if (rdy === 1'b1) begin
        exp_q.push_back(in_data);
        acc_q.push_back(cyc);
      end
      if (busy !== ~rdy) pair_ok = 1'b0;
      tick();
      if (ovld === 1'b1) begin
        n_out++;
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 24'hx;
        checks++;
        if (dig !== model_digits(e, 1'b0)) begin
          errors++;
          $display("FAIL b2b_result%0d: got %h, want %h", n_out, dig, model_digits(e, 1'b0));
        end
      end
      in_data = 24'($urandom_range(0, 24'hFFFFFF));
    end
    in_valid = 1'b0;
    checks++;
    if (acc_q.size() != 5 || n_out != 5) begin
      errors++;
      $display("FAIL b2b_count: got accepts=%0d results=%0d, want 5/5", acc_q.size(), n_out);
    end
    for (int i = 1; i < acc_q.size(); i++) begin
      checks++;
      if (acc_q[i] - acc_q[i-1] != 26) begin
        errors++;
        $display("FAIL b2b_spacing%0d: got %0d cycles, want 26", i, acc_q[i] - acc_q[i-1]);
      end
    end
    checks++;
    if (!pair_ok) begin
      errors++;
      $display("FAIL b2b_busy: busy was not the inverse of in_ready, want busy == !in_ready");
    end
    repeat (30) tick();
  endtask

  task automatic test_reset_mid();
    bit quiet;
    in_data  = 24'd654321;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (9) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checks++;
    if (rdy !== 1'b1 || busy !== 1'b0 || dig !== 24'h0 || ovf !== 1'b0 || ovld !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset: got rdy=%b busy=%b dig=%h ovf=%b vld=%b, want 1 0 000000 0 0",
               rdy, busy, dig, ovf, ovld);
    end
    quiet = 1'b1;
    repeat (40) begin
      tick();
      if (ovld !== 1'b0 || dig !== 24'h0 || ovf !== 1'b0) quiet = 1'b0;
    end
    checks++;
    if (!quiet) begin
      errors++;
      $display("FAIL mid_reset_quiet: got vld=%b dig=%h after abort, want 0 000000", ovld, dig);
    end
    rst      = 1'b1;
    in_valid = 1'b1;
    in_data  = 24'd777;
    tick();
    rst      = 1'b0;
    in_valid = 1'b0;
    checks++;
    if (rdy !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_wins: got rdy=%b busy=%b, want 1/0", rdy, busy);
    end
    convert(24'd42, "after_reset42");
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_back_to_back();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/bin_to_bcd_seq.md
Name: bin_to_bcd_seq

Overview:
Multi-cycle binary-to-BCD converter using the shift-and-add-3 (double dabble) method. Sits between the 24-bit UART data buffer PIO export and the six hex_to_7seg decoders. It replaces the combinational divide/modulo chain with a small sequential datapath. It accepts one binary word per handshake and presents registered decimal digits plus an overflow flag for the HEX0..HEX5 display path.

Parameters:
- BIN_W, 24, width of the binary input.
- OUT_DIGITS, 6, number of BCD digits driven on digits_out (one per 7-seg display).
- SATURATE, 0, behaviour on overflow: 0 = show the low OUT_DIGITS digits; 1 = force all digits to 9.

Ports:
- clk_clk  in  1  system clock (50 MHz domain).
- reset_reset  in  1  synchronous, active-high reset.
- in_data  in  BIN_W  unsigned binary value to convert.
- in_valid  in  1  in_data is valid.
- in_ready  out  1  block can accept a new word.
- digits_out  out  4*OUT_DIGITS  packed BCD; digit 0 (least significant) in [3:0].
- overflow  out  1  value exceeds 10^OUT_DIGITS - 1.
- out_valid  out  1  one-cycle pulse: digits_out and overflow were just updated.
- busy  out  1  conversion in progress.

Behaviour:
- Clock and reset: one clock, clk_clk. reset_reset is synchronous and active-high.
- Derived localparam FULL_DIGITS = ((BIN_W*1233)>>12)+1, which is 8 for BIN_W=24.
- Working shift register width is 4*FULL_DIGITS + BIN_W (56 bits at defaults).
- Iteration counter width is clog2(BIN_W+1).
- FSM states: IDLE, SHIFT, DONE.
  - IDLE: in_ready=1. On in_valid && in_ready at edge k: load {zeros, in_data} into the shift register, set counter=BIN_W, go to SHIFT.
  - SHIFT: one iteration per edge. Every BCD nibble >= 5 gets +3 (all nibbles corrected in parallel on the same edge), then the whole register shifts left by 1. The counter decrements each iteration. Iterations occur at edges k+1..k+BIN_W. After the edge where the counter reaches 0, go to DONE.
  - DONE: at edge k+BIN_W+1, register digits_out, compute overflow, assert out_valid for the following cycle, then return to IDLE.
- Latency and throughput:
  - Accept to out_valid high is BIN_W+1 edges.
  - Minimum spacing between accepts is BIN_W+2 cycles (26 at defaults).
  - out_valid is never high for two consecutive cycles.
- Handshake:
  - in_ready = (state==IDLE); busy = !in_ready.
  - in_valid while busy is ignored; the value is not latched.
  - in_data is sampled only on the accepting edge, so later changes during SHIFT have no effect.
- Overflow: overflow = OR of BCD digits OUT_DIGITS..FULL_DIGITS-1 in the final result.
  - SATURATE=0: digits_out = low OUT_DIGITS digits, i.e. value mod 10^OUT_DIGITS.
  - SATURATE=1 and overflow: every digit = 4'h9.
- Output holding: digits_out and overflow hold their last values until the next DONE. They do not change during SHIFT.
- Reset values: digits_out=0, overflow=0, out_valid=0, in_ready=1, busy=0, state=IDLE, shift register=0.
- Reset mid-conversion:
  - Abort immediately; no out_valid pulse.
  - Outputs go to their reset values.
  - in_ready=1 on the cycle after the reset edge.
- Reset and in_valid on the same edge: reset wins and the word is dropped.
- Boundary values:
  - in_data=0 yields all-zero digits.
  - in_data = 2^BIN_W-1 must not overflow the internal register, since FULL_DIGITS is sized for it.

Decomposition:
- Shared package (bcd_pkg):
  - BIN_W/OUT_DIGITS defaults.
  - FULL_DIGITS function.
  - FSM state encoding constants (IDLE=2'd0, SHIFT=2'd1, DONE=2'd2).
  - BCD nibble constants (ADD3=4'd3, NINE=4'd9).
- One sub-module: bcd_add3_col. Combinational, 4-bit in, 4-bit out, adds 3 when in >= 5. Instantiated FULL_DIGITS times via generate.
- FSM, counter and output registers stay in bin_to_bcd_seq.

Test Plan:
- Reset with in_valid low → in_ready=1, busy=0, digits_out=0, overflow=0, out_valid=0. Then accept in_data=0 → out_valid 25 edges later, digits 000000, overflow=0.
- in_data=123456 accepted at edge k → out_valid high exactly in the cycle after edge k+25, digits_out=24'h123456, overflow=0. busy=1 from k to k+24.
- in_data=999999 → 24'h999999, overflow=0. in_data=1000000 with SATURATE=0 → 24'h000000, overflow=1.
- in_data=16777215 → SATURATE=0: 24'h777215, overflow=1; SATURATE=1: 24'h999999, overflow=1.
- in_valid held high with in_data changed every cycle → in_ready low for 25 cycles after each accept, accepts exactly 26 cycles apart. Each result matches the value present on its accepting edge.
- Assert reset_reset for one cycle at iteration 10 of converting 654321 → no out_valid, outputs remain 0. The next accept of 42 yields 24'h000042.
